cdc_toggle_rx: RTL and testbench
================================

CDC_TOGGLE_RX -- requirements
Module: cdc_toggle_rx

Interface
REQ-001 Parameter DATA_W, default 8, width of the transferred data word.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4, number of synchronizer flops on req_tgl.
REQ-003 clk  input  1  single destination-domain clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset, assertion immediate, deassertion synchronous to clk by the integrator.
REQ-005 req_tgl  input  1  request toggle from the source domain, asynchronous to clk; each level change marks one new word.
REQ-006 req_data  input  DATA_W  source word; stable from the req_tgl change until the matching ack_tgl change is seen by the source.
REQ-007 ack_tgl  output  1  acknowledge toggle returned to the source; one level change per consumed word.
REQ-008 out_valid  output  1  local word available.
REQ-009 out_ready  input  1  local consumer accepts the word.
REQ-010 out_data  output  DATA_W  captured word.
REQ-011 proto_err  output  1  sticky flag: a req_tgl change was detected while a word was still held.

Function
REQ-012 req_tgl SHALL pass through a SYNC_STAGES-deep flop chain; no other logic SHALL sample req_tgl directly.
REQ-013 A request SHALL be detected when the last sync stage differs from a one-bit reference register; on detection the reference SHALL update to the sync value.
REQ-014 FSM states: IDLE, HOLD.
REQ-015 IDLE: on detection, capture req_data into the out_data register, set out_valid=1, enter HOLD, all on the same edge.
REQ-016 HOLD: on an edge with out_valid=1 and out_ready=1, clear out_valid, toggle ack_tgl, enter IDLE, all on the same edge.
REQ-017 Latency: a req_tgl change meeting setup before rising edge N SHALL give out_valid=1 after edge N+SYNC_STAGES.
REQ-018 out_data and out_valid SHALL remain stable in HOLD until the handshake edge, independent of req_data activity.
REQ-019 out_ready sampled high on the same edge that sets out_valid SHALL NOT complete a transfer; earliest transfer is the following edge.
REQ-020 Minimum IDLE->HOLD->IDLE turnaround SHALL be 1 cycle in HOLD (back-to-back words limited only by the sync latency).
REQ-021 Detection while in HOLD SHALL set proto_err=1, update the reference, and leave out_data, out_valid, and state unchanged; that request is dropped.
REQ-022 proto_err SHALL clear only on reset.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 ack_tgl SHALL be driven directly from a flop, with no combinational path to the source domain.

Reset
REQ-025 While rst_n=0: sync chain=0, reference=0, state=IDLE, out_valid=0, out_data=0, ack_tgl=0, proto_err=0.
REQ-026 Reset mid-transfer SHALL discard any held word without toggling ack_tgl.
REQ-027 The source SHALL hold req_tgl=0 through destination reset; a req_tgl=1 present after release is treated as a new request.

Verification (DATA_W=8, SYNC_STAGES=2)
REQ-028 Single word: req_data=0xA5, req_tgl 0->1 before edge 1, out_ready=1 -> out_valid=1, out_data=0xA5 after edge 3; transfer at edge 4; ack_tgl 0->1 after edge 4; out_valid=0.
REQ-029 Backpressure: word 0x3C, out_ready=0 for 10 cycles then 1 -> out_valid and out_data=0x3C held all 10 cycles; ack_tgl toggles only on the edge after out_ready rises.
REQ-030 Back-to-back: source toggles req_tgl on each ack with words 0x01, 0x02, 0x03 -> consumer receives exactly 0x01, 0x02, 0x03 in order; ack_tgl ends at 1 (three toggles); proto_err=0.
REQ-031 Protocol violation: word 0x11 held (out_ready=0), req_tgl toggles again with req_data=0x22 -> proto_err=1 two edges later; out_data stays 0x11; after out_ready=1, one transfer of 0x11, and ack_tgl toggles once.
REQ-032 Reset mid-operation: rst_n pulled low while HOLD with 0x77 -> out_valid=0, out_data=0x00, ack_tgl=0, proto_err=0 immediately; after release with req_tgl=0, no out_valid for 20 cycles.
REQ-033 Random req_tgl timing relative to clk over 1000 words with random out_ready -> no lost, duplicated, or corrupted words; proto_err=0.

Source files
------------

// File: rtl/cdc_toggle_rx.sv
// cdc_toggle_rx: destination side of a toggle-handshake word crossing.
// Synchronizes req_tgl, captures req_data once per toggle, returns ack_tgl.
module cdc_toggle_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              proto_err
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;
  logic                   r_valid;
  logic [DATA_W-1:0]      r_data;
  logic                   r_ack;
  logic                   r_err;

  logic w_sync_out;
  logic w_detect;
  logic w_capture;
  logic w_xfer;
  logic w_err_set;

  // Only the first flop of this chain ever sees the raw source toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_tgl};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_detect   = w_sync_out ^ r_ref;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= 1'b0;
    end else if (w_detect) begin
      r_ref <= w_sync_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_detect) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A new toggle here cannot be stored; it is flagged and dropped.
        if (w_detect) begin
          w_err_set = 1'b1;
        end
        if (r_valid && out_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_data  <= req_data;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
    end else if (w_xfer) begin
      r_ack <= ~r_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign ack_tgl   = r_ack;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign proto_err = r_err;

endmodule

// File: tb/tb_cdc_toggle_rx.sv
// tb_cdc_toggle_rx: directed and randomized-timing checks of cdc_toggle_rx.
// Expected values are hand-derived; the random phase uses a word scoreboard.
`timescale 1ns/1ps
module tb_cdc_toggle_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_tgl = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       ack_tgl;
  logic       out_valid;
  logic [7:0] out_data;
  logic       proto_err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int         bad_cnt;
  int         n_rx;
  int         cons_cyc;
  int         src_wait;
  logic       abort;
  logic       src_p;
  logic       src_np;
  logic       ack_prev;
  logic       ack_np;
  logic       cons_w;
  logic       cons_r;
  logic [7:0] cons_d;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  cdc_toggle_rx #(
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_tgl  (req_tgl),
    .req_data (req_data),
    .ack_tgl  (ack_tgl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    abort = 1'b0;
    n_rx  = 0;

    // reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_ack", 32'(ack_tgl), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single word, latency
    req_data  = 8'hA5;
    req_tgl   = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("lat_e1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_e2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_e3_valid", 32'(out_valid), 32'd1);
    chk("lat_e3_data", 32'(out_data), 32'hA5);
    chk("lat_e3_ack", 32'(ack_tgl), 32'd0);
    tick();
    chk("xfer_e4_valid", 32'(out_valid), 32'd0);
    chk("xfer_e4_ack", 32'(ack_tgl), 32'd1);

    // backpressure with req_data churn during HOLD
    out_ready = 1'b0;
    req_data  = 8'h3C;
    req_tgl   = 1'b0;
    repeat (3) tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", 32'(out_data), 32'h3C);
    req_data = 8'hFF;
    bad_cnt  = 0;
    repeat (10) begin
      tick();
      if (!(out_valid === 1'b1 && out_data === 8'h3C && ack_tgl === 1'b1))
        bad_cnt++;
    end
    chk("bp_hold", 32'(bad_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_ack", 32'(ack_tgl), 32'd0);
    repeat (3) tick();
    chk("idle_ready_ack", 32'(ack_tgl), 32'd0);
    chk("idle_ready_valid", 32'(out_valid), 32'd0);

    // back-to-back words
    for (int i = 1; i <= 3; i++) begin
      req_data = 8'(i);
      req_tgl  = ~req_tgl;
      for (int k = 0; k < 10 && out_valid !== 1'b1; k++) tick();
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_data", 32'(out_data), 32'(i));
      ack_prev = ack_tgl;
      ack_np   = ~ack_prev;
      tick();
      chk("b2b_ack", 32'(ack_tgl), 32'(ack_np));
    end
    chk("b2b_ack_end", 32'(ack_tgl), 32'd1);
    chk("b2b_err", 32'(proto_err), 32'd0);

    // protocol violation while holding
    out_ready = 1'b0;
    req_data  = 8'h11;
    req_tgl   = ~req_tgl;
    repeat (3) tick();
    chk("pv_valid", 32'(out_valid), 32'd1);
    chk("pv_data", 32'(out_data), 32'h11);
    req_data = 8'h22;
    req_tgl  = ~req_tgl;
    repeat (3) tick();
    chk("pv_err", 32'(proto_err), 32'd1);
    chk("pv_keep_data", 32'(out_data), 32'h11);
    chk("pv_keep_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("pv_xfer_valid", 32'(out_valid), 32'd0);
    chk("pv_xfer_ack", 32'(ack_tgl), 32'd0);
    repeat (5) tick();
    chk("pv_dropped", 32'(out_valid), 32'd0);
    chk("pv_one_ack", 32'(ack_tgl), 32'd0);
    chk("pv_sticky", 32'(proto_err), 32'd1);

    // reset while holding
    out_ready = 1'b0;
    req_data  = 8'h77;
    req_tgl   = ~req_tgl;
    repeat (3) tick();
    chk("mr_valid", 32'(out_valid), 32'd1);
    chk("mr_data", 32'(out_data), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", 32'(out_valid), 32'd0);
    chk("mr_rst_data", 32'(out_data), 32'h00);
    chk("mr_rst_ack", 32'(ack_tgl), 32'd0);
    chk("mr_rst_err", 32'(proto_err), 32'd0);
    tick();
    tick();
    rst_n   = 1'b1;
    bad_cnt = 0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b0) bad_cnt++;
    end
    chk("mr_quiet", 32'(bad_cnt), 32'd0);
    req_data = 8'h5A;
    req_tgl  = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h5A);
    out_ready = 1'b1;
    tick();
    chk("post_rst_ack", 32'(ack_tgl), 32'd1);

    // random toggle timing, random consumer readiness
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000 && !abort; i++) begin
          #($urandom_range(1, 25));
          req_data = 8'($urandom);
          exp_q.push_back(req_data);
          src_p   = ack_tgl;
          src_np  = ~src_p;
          req_tgl = ~req_tgl;
          src_wait = 0;
          while (ack_tgl === src_p && src_wait < 200) begin
            @(posedge clk);
            #1;
            src_wait++;
          end
          chk("rand_ack", 32'(ack_tgl), 32'(src_np));
          if (ack_tgl !== src_np) abort = 1'b1;
        end
      end
      begin
        cons_cyc = 0;
        while (n_rx < 1000 && cons_cyc < 60000 && !abort) begin
          cons_w    = out_valid;
          cons_d    = out_data;
          cons_r    = 1'($urandom_range(0, 1));
          out_ready = cons_r;
          @(posedge clk);
          #1;
          cons_cyc++;
          if (cons_w && cons_r) begin
            chk("rand_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              exp_w = exp_q.pop_front();
              chk("rand_data", 32'(cons_d), 32'(exp_w));
            end
            n_rx++;
          end
        end
        out_ready = 1'b0;
      end
    join
    chk("rand_count", 32'(n_rx), 32'd1000);
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_err", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
